md_sequencer: RTL

- Iterative multiply/divide sequencer for the E stage.
- Owns the HI/LO registers and runs mult, multu, div and divu as radix-2 shift-add / restoring-divide loops with a fixed latency; mthi and mtlo complete in a single cycle.
- The pipeline stalls any multdiv-class instruction in D while `start | busy` is high.

---
 rtl/md_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/md_sequencer.sv
// Iterative multiply/divide sequencer owning HI/LO: radix-2 shift-add multiply and
// restoring divide, WIDTH iterations plus one sign-fix cycle; mthi/mtlo complete at once.
module md_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               is_div_q, is_div_d;
    logic               negp_q, negp_d;
    logic               negr_q, negr_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept;
    logic               signed_op;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] x, input logic n);
        return n ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    assign accept    = (state_q == S_IDLE) && start && !cancel && (op != 3'd0) && (op != 3'd7);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MTHI) begin
                        hi_d = d1;
                    end else if (op == OP_MTLO) begin
                        lo_d = d1;
                    end else begin
                        acc_d    = {{WIDTH{1'b0}}, (signed_op ? mag(d1) : d1)};
                        opb_d    = signed_op ? mag(d2) : d2;
                        is_div_d = (op == OP_DIV) || (op == OP_DIVU);
                        negp_d   = signed_op && (d1[WIDTH-1] ^ d2[WIDTH-1]);
                        negr_d   = signed_op && d1[WIDTH-1];
                        dz_d     = (d2 == '0);
                        cnt_d    = '0;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    if (div_diff[WIDTH]) begin
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Remainder negation restores the original dividend on divide-by-zero
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : negate_w(acc_q[WIDTH-1:0], negp_q);
                    hi_d = negate_w(acc_q[2*WIDTH-1:WIDTH], negr_q);
                end else begin
                    {hi_d, lo_d} = negate_2w(acc_q, negp_q);
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            negp_q   <= negp_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
